pattern_gen: RTL and testbench

PATTERN_GEN -- requirements
Module: pattern_gen

---
 rtl/pattern_gen.sv | 145 ++++++++++++++
 tb/tb_pattern_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen.sv
// Pattern generator: emits a fixed 12-step sequence on o1..o4, holding each step
// for a dwell count latched when the sequence starts.
module pattern_gen #(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] dwell,
    output logic          o1,
    output logic          o2,
    output logic          o3,
    output logic          o4,
    output logic          busy,
    output logic          done,
    output logic [3:0]    step
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0]    LAST_STEP = 4'd12;
    localparam logic [DW-1:0] CNT_ZERO  = {DW{1'b0}};
    localparam logic [DW-1:0] CNT_ONE   = {{(DW-1){1'b0}}, 1'b1};

    // Pattern for a given step index, packed as {o1,o2,o3,o4}; idle and unused indices give 0000
    function automatic logic [3:0] step_pattern(input logic [3:0] idx);
        logic [3:0] pat;
        case (idx)
            4'd1:    pat = 4'b0010;
            4'd2:    pat = 4'b1011;
            4'd3:    pat = 4'b0000;
            4'd4:    pat = 4'b0010;
            4'd5:    pat = 4'b0100;
            4'd6:    pat = 4'b1000;
            4'd7:    pat = 4'b0001;
            4'd8:    pat = 4'b0000;
            4'd9:    pat = 4'b0001;
            4'd10:   pat = 4'b0010;
            4'd11:   pat = 4'b1000;
            4'd12:   pat = 4'b0000;
            default: pat = 4'b0000;
        endcase
        return pat;
    endfunction

    state_t        state_r, state_s;
    logic [DW-1:0] cnt_r, cnt_s;
    logic [DW-1:0] dwell_r, dwell_s;
    logic [DW-1:0] dwell_eff_s;
    logic [3:0]    step_r, step_s;
    logic [3:0]    pat_r, pat_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;

    // Next-state, counter and output-register computation
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        dwell_s     = dwell_r;
        step_s      = step_r;
        pat_s       = pat_r;
        done_s      = 1'b0;
        dwell_eff_s = (dwell == CNT_ZERO) ? CNT_ONE : dwell;

        case (state_r)
            IDLE: begin
                if (start && !abort) begin
                    state_s = RUN;
                    step_s  = 4'd1;
                    pat_s   = step_pattern(4'd1);
                    dwell_s = dwell_eff_s;
                    cnt_s   = dwell_eff_s - CNT_ONE;
                end else begin
                    state_s = IDLE;
                    step_s  = 4'd0;
                    pat_s   = 4'b0000;
                    cnt_s   = CNT_ZERO;
                end
            end
            RUN: begin
                if (abort) begin
                    state_s = IDLE;
                    step_s  = 4'd0;
                    pat_s   = 4'b0000;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else if (step_r == LAST_STEP) begin
                    state_s = IDLE;
                    step_s  = 4'd0;
                    pat_s   = 4'b0000;
                    cnt_s   = CNT_ZERO;
                    done_s  = 1'b1;
                end else begin
                    step_s = step_r + 4'd1;
                    pat_s  = step_pattern(step_r + 4'd1);
                    cnt_s  = dwell_r - CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                step_s  = 4'd0;
                pat_s   = 4'b0000;
                cnt_s   = CNT_ZERO;
            end
        endcase

        // busy is registered from the next state so it lines up with step/pattern
        busy_s = (state_s == RUN);
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            dwell_r <= CNT_ZERO;
            step_r  <= 4'd0;
            pat_r   <= 4'b0000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            dwell_r <= dwell_s;
            step_r  <= step_s;
            pat_r   <= pat_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign o1   = pat_r[3];
    assign o2   = pat_r[2];
    assign o3   = pat_r[1];
    assign o4   = pat_r[0];
    assign busy = busy_r;
    assign done = done_r;
    assign step = step_r;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed testbench for pattern_gen: a cycle table for the dwell=0 run plus
// hand-written sequences for nominal, abort, restart guards, reset and closed loop.
module tb_pattern_gen;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [11:0] dwell;
    logic        o1, o2, o3, o4;
    logic        busy;
    logic        done;
    logic [3:0]  step;

    int n_checks;
    int n_fail;

    logic [3:0] pat_tab [0:12];

    typedef struct {
        logic       start;
        logic       abort;
        logic [11:0] dwell;
        logic [3:0] exp_step;
        logic [3:0] exp_pat;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs [15];

    // Simple detector model driven by the generator outputs
    logic det_clr;
    int   det_k;
    logic det_hit;

    pattern_gen #(.DW(12)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .abort (abort),
        .dwell (dwell),
        .o1    (o1),
        .o2    (o2),
        .o3    (o3),
        .o4    (o4),
        .busy  (busy),
        .done  (done),
        .step  (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (det_clr) begin
            det_k   <= 0;
            det_hit <= 1'b0;
        end else begin
            if (det_k < 12 && {o1, o2, o3, o4} == pat_tab[det_k + 1]) begin
                det_k <= det_k + 1;
            end else if ({o1, o2, o3, o4} == pat_tab[det_k]) begin
                det_k <= det_k;
            end else if ({o1, o2, o3, o4} == pat_tab[1]) begin
                det_k <= 1;
            end else begin
                det_k <= 0;
            end
            if (det_k == 12) det_hit <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        check({name, " step"}, 32'(step), 32'd0);
        check({name, " pat"},  32'({o1, o2, o3, o4}), 32'd0);
        check({name, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        det_clr  = 1'b1;
        pat_tab[0]  = 4'b0000;
        pat_tab[1]  = 4'b0010;  pat_tab[2]  = 4'b1011;  pat_tab[3]  = 4'b0000;
        pat_tab[4]  = 4'b0010;  pat_tab[5]  = 4'b0100;  pat_tab[6]  = 4'b1000;
        pat_tab[7]  = 4'b0001;  pat_tab[8]  = 4'b0000;  pat_tab[9]  = 4'b0001;
        pat_tab[10] = 4'b0010;  pat_tab[11] = 4'b1000;  pat_tab[12] = 4'b0000;

        // dwell=0 behaves as dwell=1: one cycle per step, then done, then start+abort stays idle
        vecs[0]  = '{1'b1, 1'b0, 12'd0, 4'd1,  4'b0010, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 12'd0, 4'd2,  4'b1011, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 12'd0, 4'd3,  4'b0000, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 12'd0, 4'd4,  4'b0010, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 12'd0, 4'd5,  4'b0100, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 12'd0, 4'd6,  4'b1000, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 12'd0, 4'd7,  4'b0001, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 12'd0, 4'd8,  4'b0000, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 12'd0, 4'd9,  4'b0001, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 12'd0, 4'd10, 4'b0010, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 12'd0, 4'd11, 4'b1000, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 12'd0, 4'd12, 4'b0000, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 12'd0, 4'd0,  4'b0000, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 12'd3, 4'd0,  4'b0000, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 12'd3, 4'd0,  4'b0000, 1'b0, 1'b0};

        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        dwell = 12'd0;
        #2;
        check_idle("reset");
        check("reset done", 32'(done), 32'd0);
        tick();
        tick();
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            start = vecs[i].start;
            abort = vecs[i].abort;
            dwell = vecs[i].dwell;
            tick();
            check($sformatf("vec%0d step", i), 32'(step), 32'(vecs[i].exp_step));
            check($sformatf("vec%0d pat", i), 32'({o1, o2, o3, o4}), 32'(vecs[i].exp_pat));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].exp_done));
        end
        start = 1'b0;
        abort = 1'b0;

        // Nominal dwell=3 with a back-to-back restart after the done pulse
        begin
            int busy_cnt;
            busy_cnt = 0;
            start = 1'b1;
            dwell = 12'd3;
            for (int c = 0; c < 36; c++) begin
                tick();
                if (c == 0) start = 1'b0;
                check($sformatf("nom step c%0d", c), 32'(step), 32'(c / 3 + 1));
                check($sformatf("nom pat c%0d", c), 32'({o1, o2, o3, o4}), 32'(pat_tab[c / 3 + 1]));
                check($sformatf("nom done c%0d", c), 32'(done), 32'd0);
                if (busy) busy_cnt++;
            end
            tick();
            check_idle("nom end");
            check("nom done pulse", 32'(done), 32'd1);
            check("nom busy cycles", 32'(busy_cnt), 32'd36);
            start = 1'b1;
            dwell = 12'd1;
            tick();
            start = 1'b0;
            check("b2b step", 32'(step), 32'd1);
            check("b2b busy", 32'(busy), 32'd1);
            check("b2b done", 32'(done), 32'd0);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check_idle("b2b abort");
        end

        // Abort at step 4 with dwell=5, then a full dwell=1 run
        start = 1'b1;
        dwell = 12'd5;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 15; c++) tick();
        check("abort pre step", 32'(step), 32'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort");
        check("abort done", 32'(done), 32'd0);
        tick();
        check("abort done late", 32'(done), 32'd0);
        start = 1'b1;
        dwell = 12'd1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 12; c++) begin
            tick();
            check($sformatf("post-abort step c%0d", c), 32'(step), 32'(c + 1));
        end
        tick();
        check("post-abort done", 32'(done), 32'd1);

        // Restart guard: start re-pulsed and dwell changed at step 6 must not disturb timing
        start = 1'b1;
        dwell = 12'd5;
        for (int c = 0; c < 60; c++) begin
            tick();
            start = 1'b0;
            check($sformatf("guard step c%0d", c), 32'(step), 32'(c / 5 + 1));
            check($sformatf("guard pat c%0d", c), 32'({o1, o2, o3, o4}), 32'(pat_tab[c / 5 + 1]));
            if (c == 25) begin
                start = 1'b1;
                dwell = 12'd9;
            end
        end
        tick();
        check("guard done", 32'(done), 32'd1);
        check_idle("guard end");
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_idle("start+abort idle");

        // Asynchronous reset mid-cycle at step 8
        start = 1'b1;
        dwell = 12'd4;
        for (int c = 0; c <= 28; c++) begin
            tick();
            start = 1'b0;
        end
        check("rst pre step", 32'(step), 32'd8);
        #3;
        reset = 1'b0;
        #1;
        check_idle("async rst");
        check("async rst done", 32'(done), 32'd0);
        tick();
        check("async rst done held", 32'(done), 32'd0);
        reset = 1'b1;
        start = 1'b1;
        dwell = 12'd2;
        tick();
        start = 1'b0;
        check("post-rst start", 32'(step), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Closed loop: full dwell=2 run reaches the detector's final state
        det_clr = 1'b1;
        tick();
        det_clr = 1'b0;
        start = 1'b1;
        dwell = 12'd2;
        for (int c = 0; c < 25; c++) begin
            tick();
            start = 1'b0;
        end
        tick();
        tick();
        check("loop full hit", 32'(det_hit), 32'd1);

        // Closed loop with abort at step 7: detector must not complete
        det_clr = 1'b1;
        tick();
        det_clr = 1'b0;
        start = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            tick();
            start = 1'b0;
        end
        check("loop abort step", 32'(step), 32'd7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("loop abort hit", 32'(det_hit), 32'd0);
        check("loop abort done", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
